// File: rtl/sub_bytes_if.sv
// sub_bytes_if: handshake bundle between the round controller and sub_bytes_engine.
//   in_valid / in_ready / in_data / in_inv : upstream block transfer (byte 0 = in_data[127:120])
//   out_valid / out_ready / out_data       : downstream result transfer
//   busy                                   : engine is substituting a block
// master = controller side, slave = engine side.
interface sub_bytes_if;
  localparam int unsigned DATA_W = 128;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_inv;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, in_inv, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_inv, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: multi-cycle AES SubBytes / InvSubBytes over one 128-bit state.
// LANES bytes are substituted per BUSY cycle through LANES shared S-box lookups,
// so a block takes 16/LANES cycles; the result is held on out_data until taken.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - sub_bytes_if.slave: in_valid/in_ready/in_data/in_inv, out_valid/out_ready/out_data, busy
// Parameters:
//   LANES - bytes per BUSY cycle, one of 1, 2, 4, 8, 16
// Build option:
//   SUB_BYTES_FWD_EN - when defined the forward table is built and in_inv picks the
//   direction per block; otherwise every block uses the inverse S-box (decrypt-only).
module sub_bytes_engine #(
  parameter int unsigned LANES = 4
) (
  input  logic       clk,
  input  logic       rst,
  sub_bytes_if.slave bus
);
  localparam int unsigned STEPS = 16 / LANES;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, entry 0 first.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

`ifdef SUB_BYTES_FWD_EN
  // FIPS-197 forward S-box, entry 0 first.
  localparam logic [0:255][7:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  logic inv_q, inv_d;
`else
  logic unused_in_inv;
  assign unused_in_inv = bus.in_inv;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [0:15][7:0]   data_q, data_d;   // element 0 is byte 0 (bits 127:120)
  logic               out_valid_q, busy_q;
  logic               in_ready_c;
  logic               accept;
  logic [3:0]         idx;

  // A finished block can be swapped for a new one on the same edge it is taken.
  assign in_ready_c    = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = busy_q;

  // Next-state and datapath: substitute the current byte window in place.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx     = '0;
`ifdef SUB_BYTES_FWD_EN
    inv_d   = inv_q;
`endif
    accept  = bus.in_valid && in_ready_c;

    case (state_q)
      IDLE: if (bus.in_valid) state_d = BUSY;
      BUSY: begin
        for (int unsigned j = 0; j < LANES; j++) begin
          idx = 4'(32'(cnt_q) * LANES + j);
`ifdef SUB_BYTES_FWD_EN
          data_d[idx] = inv_q ? INV_SBOX[data_q[idx]] : FWD_SBOX[data_q[idx]];
`else
          data_d[idx] = INV_SBOX[data_q[idx]];
`endif
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase

    // Direction and data are captured only at accept.
    if (accept) begin
      data_d = bus.in_data;
      cnt_d  = '0;
`ifdef SUB_BYTES_FWD_EN
      inv_d  = bus.in_inv;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == BUSY);
    end
  end

`ifdef SUB_BYTES_FWD_EN
  // Per-block direction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inv_q <= 1'b0;
    else     inv_q <= inv_d;
  end
`endif
endmodule

// File: tb/tb_sub_bytes_engine.sv
module tb_sub_bytes_engine;
  localparam int unsigned NDUT = 3;
  localparam int unsigned LANES_K [NDUT] = '{4, 1, 16};
  localparam logic [127:0] V_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V_INV   = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] V_FWD   = 128'h637c777bf26b6fc53001672bfed7ab76;
`ifdef SUB_BYTES_FWD_EN
  localparam bit FWD_BUILD = 1'b1;
`else
  localparam bit FWD_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NDUT-1:0]        in_valid_s, in_inv_s, out_ready_s;
  logic [NDUT-1:0][127:0] in_data_s;
  logic [NDUT-1:0]        in_ready_s, out_valid_s, busy_s;
  logic [NDUT-1:0][127:0] out_data_s;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    sub_bytes_if u_if ();
    assign u_if.in_valid  = in_valid_s[k];
    assign u_if.in_data   = in_data_s[k];
    assign u_if.in_inv    = in_inv_s[k];
    assign u_if.out_ready = out_ready_s[k];
    assign in_ready_s[k]  = u_if.in_ready;
    assign out_valid_s[k] = u_if.out_valid;
    assign out_data_s[k]  = u_if.out_data;
    assign busy_s[k]      = u_if.busy;
    sub_bytes_engine #(.LANES(LANES_K[k])) u_dut (.clk(clk), .rst(rst), .bus(u_if));
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] x, y, iv, s;
    for (int xi = 0; xi < 256; xi++) begin
      x  = 8'(xi);
      iv = 8'h00;
      for (int yi = 1; yi < 256; yi++) begin
        y = 8'(yi);
        if (gmul(x, y) == 8'h01) iv = y;
      end
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = x;
    end
  endtask

  function automatic logic [127:0] model_sub(input logic [127:0] d, input logic inv);
    logic [0:15][7:0] v;
    logic use_inv;
    v = d;
    use_inv = inv | ~FWD_BUILD;
    for (int unsigned i = 0; i < 16; i++)
      v[4'(i)] = use_inv ? inv_tab[v[4'(i)]] : fwd_tab[v[4'(i)]];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one block, wait for its result; leaves the engine holding it (out_ready low).
  task automatic run_block(input logic [1:0] k, input logic [127:0] d, input logic inv,
                           output int lat, output bit to);
    int w;
    out_ready_s[k] = 1'b0;
    in_data_s[k]   = d;
    in_inv_s[k]    = inv;
    in_valid_s[k]  = 1'b1;
    w = 0;
    while (!in_ready_s[k] && w < 50) begin tick(); w++; end
    to = !in_ready_s[k];
    tick();
    in_valid_s[k] = 1'b0;
    in_data_s[k]  = {$urandom, $urandom, $urandom, $urandom};
    in_inv_s[k]   = ~inv;
    lat = 0;
    while (!out_valid_s[k] && lat < 100) begin tick(); lat++; end
    to = to | !out_valid_s[k];
  endtask

  task automatic consume(input logic [1:0] k);
    out_ready_s[k] = 1'b1;
    tick();
    out_ready_s[k] = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] kk;
    rst = 1'b1;
    tick(); tick();
    for (int unsigned i = 0; i < NDUT; i++) begin
      kk = 2'(i);
      n_cmp++; if (in_ready_s[kk] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready dut%0d got %b want 1", i, in_ready_s[kk]); end
      n_cmp++; if (out_valid_s[kk] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid dut%0d got %b want 0", i, out_valid_s[kk]); end
      n_cmp++; if (busy_s[kk] !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d got %b want 0", i, busy_s[kk]); end
      n_cmp++; if (out_data_s[kk] !== 128'h0) begin n_err++; $display("FAIL reset_out_data dut%0d got %h want 0", i, out_data_s[kk]); end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_inverse_vectors();
    logic [127:0] vin [3];
    logic [127:0] vexp [3];
    int lat;
    bit to;
    vin  = '{V_SEQ, {16{8'h63}}, {16{8'hff}}};
    vexp = '{V_INV, 128'h0, {16{8'h7d}}};
    for (int i = 0; i < 3; i++) begin
      run_block(2'd0, vin[i], 1'b1, lat, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL inv_vec%0d_timeout got timeout want result", i); end
      n_cmp++; if (out_data_s[0] !== vexp[i]) begin n_err++; $display("FAIL inv_vec%0d_data got %h want %h", i, out_data_s[0], vexp[i]); end
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL inv_vec%0d_latency got %0d want 4", i, lat); end
      consume(2'd0);
    end
  endtask

  task automatic test_direction_select();
    logic [127:0] exp;
    int lat;
    bit to;
    exp = FWD_BUILD ? V_FWD : V_INV;
    run_block(2'd0, V_SEQ, 1'b0, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL dir_sel_timeout got timeout want result"); end
    n_cmp++; if (out_data_s[0] !== exp) begin n_err++; $display("FAIL dir_sel_data got %h want %h", out_data_s[0], exp); end
    consume(2'd0);
  endtask

  task automatic test_random();
    logic [127:0] d, exp;
    logic inv;
    int lat, want_lat, nblk;
    bit to;
    for (int i = 0; i < 3; i++) begin
      want_lat = int'(16 / LANES_K[i]);
      nblk = (i == 0) ? 12 : 4;
      for (int b = 0; b < nblk; b++) begin
        d   = {$urandom, $urandom, $urandom, $urandom};
        inv = 1'($urandom_range(0, 1));
        exp = model_sub(d, inv);
        run_block(2'(i), d, inv, lat, to);
        n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL rand_timeout lanes%0d blk%0d got timeout want result", LANES_K[i], b); end
        n_cmp++; if (out_data_s[i] !== exp) begin n_err++; $display("FAIL rand_data lanes%0d blk%0d got %h want %h", LANES_K[i], b, out_data_s[i], exp); end
        n_cmp++; if (lat !== want_lat) begin n_err++; $display("FAIL rand_latency lanes%0d blk%0d got %0d want %0d", LANES_K[i], b, lat, want_lat); end
        consume(2'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, exp;
    int lat;
    bit to;
    d   = {$urandom, $urandom, $urandom, $urandom};
    exp = model_sub(d, 1'b1);
    run_block(2'd0, d, 1'b1, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL bp_timeout got timeout want result"); end
    in_valid_s[0] = 1'b1;
    in_data_s[0]  = ~d;
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (out_data_s[0] !== exp) begin n_err++; $display("FAIL bp_hold_data cyc%0d got %h want %h", c, out_data_s[0], exp); end
      n_cmp++; if (out_valid_s[0] !== 1'b1) begin n_err++; $display("FAIL bp_out_valid cyc%0d got %b want 1", c, out_valid_s[0]); end
      n_cmp++; if (in_ready_s[0] !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d got %b want 0", c, in_ready_s[0]); end
      tick();
    end
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    tick();
    out_ready_s[0] = 1'b0;
    n_cmp++; if (out_valid_s[0] !== 1'b0) begin n_err++; $display("FAIL bp_release_out_valid got %b want 0", out_valid_s[0]); end
    n_cmp++; if (in_ready_s[0] !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready_s[0]); end
    n_cmp++; if (busy_s[0] !== 1'b0) begin n_err++; $display("FAIL bp_release_busy got %b want 0", busy_s[0]); end
  endtask

  task automatic test_back_to_back(input logic [1:0] k);
    logic [127:0] blk [4];
    logic         bi  [4];
    logic [127:0] exp;
    int n_in, n_out, cyc;
    bit hs, acc, prev_hs;
    for (int i = 0; i < 4; i++) begin
      blk[i] = {$urandom, $urandom, $urandom, $urandom};
      bi[i]  = 1'($urandom_range(0, 1));
    end
    n_in = 0; n_out = 0; cyc = 0; prev_hs = 1'b0;
    out_ready_s[k] = 1'b1;
    in_data_s[k]   = blk[0];
    in_inv_s[k]    = bi[0];
    in_valid_s[k]  = 1'b1;
    while (n_out < 4 && cyc < 400) begin
      hs  = out_valid_s[k] & out_ready_s[k];
      acc = in_valid_s[k] & in_ready_s[k];
      if (prev_hs) begin
        n_cmp++; if (out_valid_s[k] !== 1'b0) begin n_err++; $display("FAIL b2b_drop lanes%0d got %b want 0", LANES_K[k], out_valid_s[k]); end
      end
      if (hs) begin
        exp = model_sub(blk[n_out], bi[n_out]);
        n_cmp++; if (out_data_s[k] !== exp) begin n_err++; $display("FAIL b2b_data lanes%0d blk%0d got %h want %h", LANES_K[k], n_out, out_data_s[k], exp); end
        if (n_in < 4) begin
          n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_zero_bubble lanes%0d blk%0d got %b want 1", LANES_K[k], n_out, acc); end
        end
        n_out++;
      end
      prev_hs = hs;
      tick();
      cyc++;
      if (acc) begin
        n_in++;
        if (n_in < 4) begin
          in_data_s[k] = blk[n_in];
          in_inv_s[k]  = bi[n_in];
        end else begin
          in_valid_s[k] = 1'b0;
        end
      end
    end
    n_cmp++; if (n_out !== 4) begin n_err++; $display("FAIL b2b_complete lanes%0d got %0d results want 4", LANES_K[k], n_out); end
    in_valid_s[k]  = 1'b0;
    out_ready_s[k] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] d, exp;
    int lat;
    bit to;
    in_data_s[0]  = {$urandom, $urandom, $urandom, $urandom};
    in_inv_s[0]   = 1'b1;
    in_valid_s[0] = 1'b1;
    tick();
    in_valid_s[0] = 1'b0;
    tick();
    n_cmp++; if (busy_s[0] !== 1'b1) begin n_err++; $display("FAIL midbusy_busy got %b want 1", busy_s[0]); end
    n_cmp++; if (in_ready_s[0] !== 1'b0) begin n_err++; $display("FAIL midbusy_in_ready got %b want 0", in_ready_s[0]); end
    rst = 1'b1;
    tick();
    n_cmp++; if (in_ready_s[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready_s[0]); end
    n_cmp++; if (out_valid_s[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid_s[0]); end
    n_cmp++; if (busy_s[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy_s[0]); end
    n_cmp++; if (out_data_s[0] !== 128'h0) begin n_err++; $display("FAIL rst_mid_out_data got %h want 0", out_data_s[0]); end
    rst = 1'b0;
    tick();
    d   = {$urandom, $urandom, $urandom, $urandom};
    exp = model_sub(d, 1'b1);
    run_block(2'd0, d, 1'b1, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL post_rst_timeout got timeout want result"); end
    n_cmp++; if (out_data_s[0] !== exp) begin n_err++; $display("FAIL post_rst_data got %h want %h", out_data_s[0], exp); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL post_rst_latency got %0d want 4", lat); end
    consume(2'd0);
  endtask

  initial begin
    rst         = 1'b1;
    in_valid_s  = '0;
    in_inv_s    = '0;
    out_ready_s = '0;
    in_data_s   = '0;
    build_tables();
    test_reset();
    test_inverse_vectors();
    test_direction_select();
    test_random();
    test_backpressure();
    for (int i = 0; i < 3; i++) test_back_to_back(2'(i));
    test_reset_mid_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
